// File: rtl/loader_pkg.sv
// Shared types and constants for the simple-computer program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        HDR,
        LOAD,
        CHK,
        FILL,
        RUN,
        ERR
    } state_t;

    localparam logic [3:0] op_nop = 4'h0;
    localparam logic [3:0] op_lda = 4'h1;
    localparam logic [3:0] op_add = 4'h2;
    localparam logic [3:0] op_sub = 4'h3;
    localparam logic [3:0] op_sta = 4'h4;
    localparam logic [3:0] op_ldi = 4'h5;
    localparam logic [3:0] op_jmp = 4'h6;
    localparam logic [3:0] op_jc  = 4'h7;
    localparam logic [3:0] op_jz  = 4'h8;
    localparam logic [3:0] op_out = 4'hE;
    localparam logic [3:0] op_hlt = 4'hF;

    localparam logic [7:0] fill_word_default = {op_nop, 4'h0};

endpackage

// File: rtl/prog_loader.sv
// Loads a length-prefixed, checksummed word stream into board RAM and holds
// the CPU in reset until the image checks good.
//
// state | meaning
// HDR   | waiting for header word L
// LOAD  | writing data words to RAM[0..L-1], accumulating sum
// CHK   | waiting for checksum word, compare against sum
// FILL  | padding RAM[L..DEPTH-1] with FILL_WORD
// RUN   | image good, CPU released
// ERR   | bad header or checksum, CPU held
module prog_loader
    import loader_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int FILL_EN = 1,
    parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(fill_word_default)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] depth_c = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   len;
    logic [DATA_W-1:0] sum;
    logic              accept;
    logic              hdr_bad;

    assign accept  = in_valid && in_ready;
    assign hdr_bad = (in_data == '0) || (in_data > DATA_W'(DEPTH));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= HDR;
            cnt       <= '0;
            len       <= '0;
            sum       <= '0;
            in_ready  <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            ram_we <= 1'b0;
            case (state)
                HDR: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (hdr_bad) begin
                            state    <= ERR;
                            err      <= 1'b1;
                            in_ready <= 1'b0;
                        end else begin
                            len   <= in_data[ADDR_W:0];
                            cnt   <= '0;
                            sum   <= '0;
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        ram_we    <= 1'b1;
                        ram_addr  <= cnt[ADDR_W-1:0];
                        ram_wdata <= in_data;
                        sum       <= sum + in_data;
                        cnt       <= cnt + 1'b1;
                        if (cnt == len - 1'b1) begin
                            state <= CHK;
                        end
                    end
                end
                CHK: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (in_data != sum) begin
                            state <= ERR;
                            err   <= 1'b1;
                        end else if ((FILL_EN != 0) && (len < depth_c)) begin
                            // First pad write goes out alongside the state change
                            state     <= FILL;
                            ram_we    <= 1'b1;
                            ram_addr  <= len[ADDR_W-1:0];
                            ram_wdata <= FILL_WORD;
                            cnt       <= len + 1'b1;
                        end else begin
                            state    <= RUN;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end
                    end
                end
                FILL: begin
                    if (cnt == depth_c) begin
                        state    <= RUN;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        ram_we    <= 1'b1;
                        ram_addr  <= cnt[ADDR_W-1:0];
                        ram_wdata <= FILL_WORD;
                        cnt       <= cnt + 1'b1;
                    end
                end
                RUN, ERR: begin
                    if (reload) begin
                        state    <= HDR;
                        in_ready <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        cpu_hold <= 1'b1;
                    end
                end
                default: begin
                    state    <= HDR;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized scoreboard bench for prog_loader against a stream-level model.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       reload = 1'b0;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       cpu_hold;
    logic       done;
    logic       err;

    int total = 0;
    int bad = 0;
    logic [11:0] exp_q[$];
    logic [7:0]  img[$];

    prog_loader #(.DATA_W(8), .ADDR_W(4), .FILL_EN(1), .FILL_WORD(8'h00)) dut (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .reload(reload), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .cpu_hold(cpu_hold),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Scoreboard monitor: every RAM write must match the next expected write
    always @(negedge clk) begin
        logic [11:0] e;
        if (ram_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {ram_addr, ram_wdata}, 12'hxxx);
            end else begin
                e = exp_q.pop_front();
                check("ram_addr", 32'(ram_addr), 32'(e[11:8]));
                check("ram_wdata", 32'(ram_wdata), 32'(e[7:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] w, input int gapmax);
        int g;
        int t;
        g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
        repeat (g) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            tick();
        end
        in_valid = 1'b1;
        in_data  = w;
        t = 0;
        while (!in_ready && t < 200) begin
            tick();
            t++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            tick();
            in_valid = 1'b0;
        end
    endtask

    task automatic do_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        check("reload_cpu_hold", 32'(cpu_hold), 32'd1);
        check("reload_done", 32'(done), 32'd0);
        check("reload_err", 32'(err), 32'd0);
        check("reload_in_ready", 32'(in_ready), 32'd1);
    endtask

    // img holds the data words; csum_delta != 0 corrupts the checksum
    task automatic load_image(input logic [7:0] l, input logic [7:0] csum_delta, input int gapmax);
        int sum;
        int n;
        if (l == 8'd0 || l > 8'd16) begin
            send(l, gapmax);
            check("hdr_err", 32'(err), 32'd1);
            check("hdr_cpu_hold", 32'(cpu_hold), 32'd1);
            check("hdr_ram_we", 32'(ram_we), 32'd0);
            check("hdr_in_ready", 32'(in_ready), 32'd0);
            return;
        end
        sum = 0;
        for (int i = 0; i < int'(l); i++) begin
            sum = (sum + int'(img[i])) % 256;
            exp_q.push_back({4'(i), img[i]});
        end
        send(l, gapmax);
        for (int i = 0; i < int'(l); i++) send(img[i], gapmax);
        if (csum_delta == 8'd0) begin
            n = 16 - int'(l);
            for (int k = 0; k < n; k++) exp_q.push_back({4'(int'(l) + k), 8'h00});
            send(8'(sum), gapmax);
            for (int k = 0; k < n; k++) begin
                check("fill_we", 32'(ram_we), 32'd1);
                check("fill_in_ready", 32'(in_ready), 32'd0);
                check("fill_done", 32'(done), 32'd0);
                check("fill_cpu_hold", 32'(cpu_hold), 32'd1);
                tick();
            end
            check("run_done", 32'(done), 32'd1);
            check("run_cpu_hold", 32'(cpu_hold), 32'd0);
            check("run_ram_we", 32'(ram_we), 32'd0);
            check("run_in_ready", 32'(in_ready), 32'd0);
            check("run_err", 32'(err), 32'd0);
        end else begin
            send(8'(sum + int'(csum_delta)), gapmax);
            check("chk_err", 32'(err), 32'd1);
            check("chk_cpu_hold", 32'(cpu_hold), 32'd1);
            check("chk_done", 32'(done), 32'd0);
            check("chk_ram_we", 32'(ram_we), 32'd0);
            check("chk_in_ready", 32'(in_ready), 32'd0);
            tick();
            check("chk_done_stays", 32'(done), 32'd0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] l;
        logic [7:0] d;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        tick();
        check("rst_in_ready_held", 32'(in_ready), 32'd0);
        clr = 1'b0;
        tick();
        check("in_ready_after_clr", 32'(in_ready), 32'd1);

        img = '{8'h1E, 8'h2F, 8'hE0, 8'hF0};
        load_image(8'd4, 8'd0, 0);
        do_reload();
        load_image(8'd4, 8'hFF, 0);
        do_reload();
        load_image(8'h11, 8'd0, 0);
        do_reload();
        load_image(8'h00, 8'd0, 0);
        do_reload();

        img = {};
        for (int i = 0; i < 16; i++) img.push_back(8'(i));
        load_image(8'h10, 8'd0, 0);
        do_reload();

        // clr after two data words of a four-word image
        img = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        exp_q.push_back({4'h0, 8'hA1});
        exp_q.push_back({4'h1, 8'hB2});
        send(8'd4, 0);
        send(8'hA1, 0);
        send(8'hB2, 0);
        @(negedge clk);
        #1;
        clr = 1'b1;
        #1;
        check("clr_in_ready", 32'(in_ready), 32'd0);
        check("clr_ram_we", 32'(ram_we), 32'd0);
        check("clr_ram_addr", 32'(ram_addr), 32'd0);
        check("clr_ram_wdata", 32'(ram_wdata), 32'd0);
        check("clr_cpu_hold", 32'(cpu_hold), 32'd1);
        check("clr_done", 32'(done), 32'd0);
        check("clr_err", 32'(err), 32'd0);
        tick();
        clr = 1'b0;
        check("clr_in_ready_low", 32'(in_ready), 32'd0);
        tick();
        check("clr_in_ready_rise", 32'(in_ready), 32'd1);
        load_image(8'd4, 8'd0, 2);
        do_reload();

        for (int r = 0; r < 12; r++) begin
            img = {};
            case ($urandom_range(0, 5))
                0: l = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(17, 255));
                default: l = 8'($urandom_range(1, 16));
            endcase
            for (int i = 0; i < int'(l) && i < 16; i++) img.push_back(8'($urandom));
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            load_image(l, d, 3);
            do_reload();
        end

        repeat (3) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Parametrised program loader for the simple-computer board. It accepts a length-prefixed, checksummed word stream over a valid/ready handshake and writes the words into the board RAM starting at address 0. Unused addresses can optionally be padded with a fill word. The CPU is held in reset until the image checks good, and a reload request restarts loading without a board reset.

## Interface
Parameters:
- DATA_W, 8, RAM word width; must be > ADDR_W
- ADDR_W, 4, RAM address width; DEPTH = 2**ADDR_W
- FILL_EN, 1, pad addresses L..DEPTH-1 after a good load
- FILL_WORD, 0, pad value (NOP opcode in low-order form)

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  reset, asynchronous, active-high
- in_valid  in  1  stream word valid
- in_data  in  DATA_W  stream word
- in_ready  out  1  loader can accept a word
- reload  in  1  single-cycle request to restart loading
- ram_we  out  1  RAM write strobe
- ram_addr  out  ADDR_W  RAM write address
- ram_wdata  out  DATA_W  RAM write data
- cpu_hold  out  1  holds CPU in reset (drive board clr)
- done  out  1  image loaded and CPU released
- err  out  1  load failed

## Operation
- Stream format: header word L, then L data words, then checksum word C. C = sum of the data words mod 2**DATA_W; the header is not included in the sum.
- States:
  - HDR: in_ready=1. On accept: if L==0 or L>DEPTH, go to ERR. Otherwise set cnt=0, sum=0, go to LOAD.
  - LOAD: in_ready=1. Each accept writes RAM[cnt]=word, sets sum+=word and cnt++. On the accept where cnt==L-1, go to CHK.
  - CHK: in_ready=1. On accept: if C!=sum, go to ERR. If C==sum, go to FILL when FILL_EN=1 and L<DEPTH, else go to RUN.
  - FILL: in_ready=0. Writes FILL_WORD to address L through DEPTH-1, one per cycle, then goes to RUN.
  - RUN: cpu_hold=0, done=1, in_ready=0.
  - ERR: err=1, cpu_hold=1, in_ready=0.
- reload in RUN or ERR:
  - Go to HDR next cycle.
  - Set done=0, err=0, cpu_hold=1.
  - RAM contents are not cleared.
- reload in HDR, LOAD, CHK or FILL is ignored.
- cnt is ADDR_W+1 bits wide so that L==DEPTH terminates correctly. sum wraps modulo 2**DATA_W.

## Timing
- Reset values:
  - State HDR.
  - in_ready=0 while clr is high; it rises in the first cycle after clr falls.
  - ram_we=0, ram_addr=0, ram_wdata=0.
  - cpu_hold=1, done=0, err=0.
- A transfer happens on a rising edge with in_valid && in_ready. in_ready is decoded from state, so it drops in the cycle after the final CHK accept. in_valid gaps stall with no side effects.
- RAM outputs are registered. ram_we is high in the cycle after a data-word accept, with matching addr and wdata.
- FILL issues DEPTH-L consecutive ram_we cycles, starting the cycle after the CHK accept.
- done and cpu_hold change in the cycle after the last ram_we. Without fill, they change in the cycle after the CHK accept.
- err rises in the cycle after the offending header or checksum accept.
- clr mid-operation:
  - Immediately forces the reset values.
  - Any partial image stays in RAM.
  - The loader restarts at HDR.

## Structure
- Shared package loader_pkg holds:
  - State enum: HDR, LOAD, CHK, FILL, RUN, ERR.
  - Opcode constants: nop=0, lda=1, add=2, sub=3, sta=4, ldi=5, jmp=6, jc=7, jz=8, out=E, hlt=F.
  - Default FILL_WORD = {nop, 0}.
- A single module is sufficient; no sub-module is required. The checksum accumulator and counter stay inline.

## Test plan
- Good load with fill: send L=04, then 1E 2F E0 F0, then C=1D. Required: RAM[0..3]=1E,2F,E0,F0; 12 fill writes of 00 to addresses 4..F; done=1 and cpu_hold=0 one cycle after the addr F write. With RAM[E]=38 and RAM[F]=23 preset by the bench and FILL_EN=0, the board outputs 5B.
- Bad checksum: same stream with C=1C. Required: err=1 and cpu_hold=1 one cycle after the checksum accept; no fill writes; done stays 0.
- Bad header: L=11 (DEPTH=16), then L=00 after a reload. Required: err=1 each time, immediately after the header; zero RAM writes.
- Full image: L=10 with 16 words 00..0F, then C=78. Required: 16 writes, no FILL cycles, done=1 one cycle after the addr F write.
- Backpressure and gaps: random in_valid gaps during LOAD. Required: write order and addresses unchanged; in_ready=0 is observed in FILL and RUN.
- Reset and reload: assert clr after 2 data words. Required: all outputs at reset values, restart at HDR, and a following good load succeeds. Then pulse reload in RUN. Required: cpu_hold=1 and done=0 next cycle; a second image loads correctly.
